// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (lo = quotient, hi = remainder).
// Optional macro DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              busy_nxt, done_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              sgn_q, dvd_neg, dsr_neg, dvz;
  logic [DATA_W-1:0] dvd, dsr, rem;
  logic [DATA_W-1:0] mag_1, mag_2;
  logic              accept, early;
  logic [DATA_W-1:0] rem_sh;
  logic [DATA_W:0]   diff;
  logic              ge;

  // Magnitudes are taken only for signed divides; 2^31 maps onto itself, which is correct unsigned.
  assign mag_1  = (is_signed && operand_1[DATA_W-1]) ? DATA_W'(-operand_1) : operand_1;
  assign mag_2  = (is_signed && operand_2[DATA_W-1]) ? DATA_W'(-operand_2) : operand_2;
  assign accept = (state == IDLE) && start && !flush;

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag_2 != '0) && (mag_1 < mag_2);
`else
  assign early = 1'b0;
`endif

  // One restoring step; the partial remainder never exceeds DATA_W bits after the shift.
  assign rem_sh = {rem[DATA_W-2:0], dvd[DATA_W-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dsr};
  assign ge     = ~diff[DATA_W];

  // State and registered control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start) state_nxt = early ? FIX : CALC;
        CALC: if (cnt == CNT_W'(DATA_W - 1)) state_nxt = FIX;
        FIX:  state_nxt = DONE;
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control outputs track the upcoming state so they line up with it after the edge
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // Datapath: operand capture, iteration, sign fix-up and result write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      sgn_q   <= 1'b0;
      dvd_neg <= 1'b0;
      dsr_neg <= 1'b0;
      dvz     <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      cnt     <= '0;
      sgn_q   <= is_signed;
      dvd_neg <= operand_1[DATA_W-1];
      dsr_neg <= operand_2[DATA_W-1];
      dvz     <= (operand_2 == '0);
      dsr     <= mag_2;
      rem     <= early ? mag_1 : '0;
      dvd     <= early ? '0 : mag_1;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      dvd <= {dvd[DATA_W-2:0], ge};
      rem <= ge ? diff[DATA_W-1:0] : rem_sh;
    end else if (state == FIX && !flush) begin
      // Divide by zero forces all-ones quotient; remainder fix-up restores the raw dividend
      if (dvz)
        lo <= '1;
      else if (sgn_q && (dvd_neg != dsr_neg))
        lo <= DATA_W'(-dvd);
      else
        lo <= dvd;
      hi <= (sgn_q && dvd_neg) ? DATA_W'(-rem) : rem;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus flush, reset and start-in-DONE sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        early;
  } vec_t;

  vec_t vecs[14];

  div_unit #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Start one divide and watch 40 cycles; cycle k is observed at the k-th falling edge after the start edge
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int exp_lat, input string nm);
    int done_at = 0;
    int ndone = 0;
    int bad_busy = 0;
    logic [31:0] got_lo = '0;
    logic [31:0] got_hi = '0;
    @(negedge clk);
    start = 1'b1; is_signed = sgn; operand_1 = a; operand_2 = b;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; is_signed = ~sgn; operand_1 = $urandom; operand_2 = $urandom;
      end
      if (busy !== (k <= exp_lat)) bad_busy++;
      if (done === 1'b1) begin
        ndone++;
        if (done_at == 0) begin
          done_at = k; got_lo = lo; got_hi = hi;
        end
      end
    end
    chk({nm, " done_cycle"}, 32'(done_at), 32'(exp_lat));
    chk({nm, " done_pulses"}, 32'(ndone), 32'd1);
    chk({nm, " busy_bad_cycles"}, 32'(bad_busy), 32'd0);
    chk({nm, " lo"}, got_lo, exp_lo);
    chk({nm, " hi"}, got_hi, exp_hi);
    chk({nm, " lo_hold"}, lo, exp_lo);
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    bit seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          1'b0};
    vecs[3]  = '{1'b1, 32'h12345678,   32'h0,          32'hFFFFFFFF,   32'h12345678,   1'b0};
    vecs[4]  = '{1'b0, 32'h12345678,   32'h0,          32'hFFFFFFFF,   32'h12345678,   1'b0};
    vecs[5]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b1};
    vecs[6]  = '{1'b1, 32'hFFFFFFFB,   32'd9,          32'd0,          32'hFFFFFFFB,   1'b1};
    vecs[7]  = '{1'b0, 32'd9,          32'd5,          32'd1,          32'd4,          1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFE,   32'd1,          32'd1,          1'b0};
    vecs[9]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[11] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000,   32'h0,          1'b0};
    vecs[12] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b1};
    vecs[13] = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1'b1};

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    operand_1 = '0; operand_2 = '0;
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      lat = (EARLY_EN && vecs[i].early) ? 2 : 34;
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_lo, vecs[i].exp_hi, lat,
              $sformatf("vec%0d", i));
    end

    // Flush mid-divide: busy drops, no done, results untouched
    run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, "pre_flush");
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; operand_1 = 32'd50; operand_2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy_next", 32'(busy), 32'd0);
    nbusy = 0; ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) ndone++;
    end
    chk("flush busy_after", 32'(nbusy), 32'd0);
    chk("flush done_after", 32'(ndone), 32'd0);
    chk("flush lo_kept", lo, 32'd14);
    chk("flush hi_kept", hi, 32'd2);

    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, "post_flush");

    // start and flush together: nothing begins
    @(negedge clk);
    start = 1'b1; flush = 1'b1; operand_1 = 32'd77; operand_2 = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    nbusy = 0; ndone = 0;
    repeat (40) begin
      if (busy) nbusy++;
      if (done) ndone++;
      @(negedge clk);
    end
    chk("startflush busy", 32'(nbusy), 32'd0);
    chk("startflush done", 32'(ndone), 32'd0);
    chk("startflush lo_kept", lo, 32'd3);

    // Asynchronous reset mid-divide
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; operand_1 = 32'd200; operand_2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst busy", 32'(busy), 32'd0);
    chk("async_rst done", 32'(done), 32'd0);
    chk("async_rst hi", hi, 32'd0);
    chk("async_rst lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start presented during the DONE cycle is ignored
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; operand_1 = 32'd100; operand_2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    chk("done_start seen_done", 32'(seen), 32'd1);
    start = 1'b1; operand_1 = 32'd9; operand_2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("done_start busy_drop", 32'(busy), 32'd0);
    chk("done_start done_drop", 32'(done), 32'd0);
    nbusy = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("done_start stays_idle", 32'(nbusy), 32'd0);
    chk("done_start lo", lo, 32'd14);
    chk("done_start hi", hi, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
